ans_rx_parse: RTL and testbench
===============================

// Module: ans_rx_parse
// PURPOSE
//  Receive side of the phase/frequency ASCII report link. Takes raw UART serial input and parses lines
//  "P1,P2,P3,P4,F\r\n": P1..P4 are 8 hex chars (29-bit, first char '0'/'1'), F is 7 hex chars (28-bit).
//  Valid lines are committed atomically to output registers with a one-cycle strobe.
//  Used on the host/loopback FPGA, or for self-test looped back against the report transmitter.
// PARAMETERS
//  BAUD_DIV   234   i_clk cycles per UART bit (27 MHz / 115200); passed to uart_rx
//  ERR_W      8     width of saturating error counter
// PORTS
//  i_clk      in   1      system clock
//  i_rst_n    in   1      asynchronous, active-low reset
//  i_uart_rx  in   1      UART serial in, idle high, 8N1
//  o_ph1      out  29     phase 1 of last valid line
//  o_ph2      out  29     phase 2 of last valid line
//  o_ph3      out  29     phase 3 of last valid line
//  o_ph4      out  29     phase 4 of last valid line
//  o_freq     out  28     frequency count of last valid line
//  o_valid    out  1      1-cycle pulse: o_ph*/o_freq updated this cycle
//  o_err      out  1      1-cycle pulse: line rejected
//  o_err_cnt  out  ERR_W  rejected-line count, saturates at all-ones
// BEHAVIOUR
//  - Reset: all outputs 0; FSM -> ST_DATA, field=0, nib=0; shadow regs 0.
//  - uart_rx delivers byte + 1-cycle strobe + frame-error flag. Parser acts only on strobe cycles.
//  - Hex classes: '0'-'9', 'A'-'F', 'a'-'f' -> nibble 0..15. Any other char in a hex slot is an error.
//  - ST_DATA (field 0..4, nib 0..7):
//    shadow[field] <= {shadow[field], nibble}, truncated to field width; nib++.
//    Fields 0-3, nib 0: char must be '0' or '1', else error.
//    After nib 7 of fields 0-3 -> ST_SEP. After nib 6 of field 4 -> ST_CR.
//  - ST_SEP: ',' -> field++, nib=0, ST_DATA; other -> error.
//  - ST_CR: 0x0D -> ST_LF; other -> error.
//  - ST_LF: 0x0A -> commit; other -> error.
//  - Commit: cycle after the LF strobe, o_ph1..4/o_freq <= shadows and o_valid=1; FSM -> ST_DATA, field/nib=0.
//  - Error (bad char, frame error, early LF): o_err pulses the cycle after the offending strobe;
//    o_err_cnt++ unless saturated; outputs untouched.
//    If the offending byte was 0x0A -> ST_DATA (restart at start of line); else -> ST_SYNC.
//  - ST_SYNC: discard bytes until 0x0A, then ST_DATA. No further o_err inside ST_SYNC.
//  - 0x0A in any state other than ST_LF/ST_SYNC = error with immediate restart (one o_err per bad line).
//  - Shadows are not cleared between lines; every field is fully rewritten before any commit.
//  - o_valid and o_err are never asserted in the same cycle.
//  - First line after reset is accepted only if it starts cleanly. A partial line (mid-stream start)
//    errors once, resyncs at its LF, and the next line is accepted.
//  - Reset mid-line: immediate return to reset state; partial shadows discarded.
// STRUCTURE
//  - Shared package/header: ASCII constants (CHR_COMMA 8'h2C, CHR_CR 8'h0D, CHR_LF 8'h0A),
//    field widths (PH_W=29, FREQ_W=28), line length 45, FSM state encodings.
//    The transmitter uses the same constants.
//  - One sub-module: uart_rx (start-bit detect at mid-bit, 16x or BAUD_DIV/2 sampling, stop-bit check,
//    outputs o_data[7:0], o_rxvalid, o_ferr). Parser FSM and hex decode function stay in this module.
// TESTING
//  1. "0ABCDEF0,1FFFFFFF,00000000,12345678,19BFCC0\r\n" -> o_valid once;
//     ph1=29'h0ABCDEF0, ph2=29'h1FFFFFFF, ph3=0, ph4=29'h12345678, freq=28'h19BFCC0; o_err never.
//  2. Same line with lowercase "0abcdef0" -> identical outputs to scenario 1.
//  3. Valid line, then line with ph2 first char '2' -> o_err 1 pulse, err_cnt=1, outputs still
//     scenario-1 values; following valid line commits.
//  4. "0123\n" then valid line -> o_err once at LF, no resync wait; next line gives o_valid.
//  5. Garbage "XYZ,,12\r\n" then valid line -> exactly one o_err, then o_valid with correct values.
//     Also: bit with stop bit forced low -> error + resync.
//  6. Assert i_rst_n low at byte 20 of a line -> all outputs 0; next full line commits.
//     Then 300 bad lines -> o_err_cnt saturates at 8'hFF.

Source files
------------

// File: rtl/ans_rx_parse_pkg.sv
// Shared constants for the phase/frequency ASCII report link (receiver and transmitter).
package ans_rx_parse_pkg;

  localparam logic [7:0] CHR_COMMA = 8'h2C;
  localparam logic [7:0] CHR_CR    = 8'h0D;
  localparam logic [7:0] CHR_LF    = 8'h0A;

  localparam int unsigned PH_W     = 29;
  localparam int unsigned FREQ_W   = 28;
  localparam int unsigned LINE_LEN = 45;

  localparam logic [2:0] ST_DATA = 3'd0;
  localparam logic [2:0] ST_SEP  = 3'd1;
  localparam logic [2:0] ST_CR   = 3'd2;
  localparam logic [2:0] ST_LF   = 3'd3;
  localparam logic [2:0] ST_SYNC = 3'd4;

endpackage

// File: rtl/ans_rx_parse_uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, one-cycle byte strobe with framing-error flag.
module ans_rx_parse_uart_rx #(
  parameter int unsigned BAUD_DIV = 234
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_rxvalid,
  output logic       o_ferr
);

  localparam int unsigned CNT_W = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(BAUD_DIV / 2 - 1);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  logic             rx_s1, rx_s2, rx_d;
  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       bitn, bitn_nxt;
  logic [7:0]       shreg, shreg_nxt;
  logic [7:0]       data_nxt;
  logic             valid_nxt, ferr_nxt;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      rx_s1 <= i_rx;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    bitn_nxt  = bitn;
    shreg_nxt = shreg;
    data_nxt  = o_data;
    valid_nxt = 1'b0;
    ferr_nxt  = 1'b0;
    case (state)
      RX_IDLE: begin
        // A real falling edge is required, so a held-low break is not re-read as a start bit
        if (rx_d && !rx_s2) begin
          state_nxt = RX_START;
          cnt_nxt   = '0;
        end
      end
      RX_START: begin
        if (cnt == CNT_HALF) begin
          cnt_nxt   = '0;
          bitn_nxt  = '0;
          state_nxt = rx_s2 ? RX_IDLE : RX_DATA;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (cnt == CNT_FULL) begin
          cnt_nxt   = '0;
          shreg_nxt = {rx_s2, shreg[7:1]};
          if (bitn == 3'd7) state_nxt = RX_STOP;
          else              bitn_nxt  = bitn + 3'd1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        if (cnt == CNT_FULL) begin
          cnt_nxt   = '0;
          data_nxt  = shreg;
          valid_nxt = 1'b1;
          ferr_nxt  = !rx_s2;
          state_nxt = RX_IDLE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= RX_IDLE;
      cnt       <= '0;
      bitn      <= '0;
      shreg     <= '0;
      o_data    <= '0;
      o_rxvalid <= 1'b0;
      o_ferr    <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      bitn      <= bitn_nxt;
      shreg     <= shreg_nxt;
      o_data    <= data_nxt;
      o_rxvalid <= valid_nxt;
      o_ferr    <= ferr_nxt;
    end
  end

endmodule

// File: rtl/ans_rx_parse.sv
// Parses "P1,P2,P3,P4,F\r\n" report lines from the UART and commits valid lines atomically.
module ans_rx_parse
  import ans_rx_parse_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 234,
  parameter int unsigned ERR_W    = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_uart_rx,
  output logic [PH_W-1:0]   o_ph1,
  output logic [PH_W-1:0]   o_ph2,
  output logic [PH_W-1:0]   o_ph3,
  output logic [PH_W-1:0]   o_ph4,
  output logic [FREQ_W-1:0] o_freq,
  output logic              o_valid,
  output logic              o_err,
  output logic [ERR_W-1:0]  o_err_cnt
);

  logic [7:0] rx_data;
  logic       rx_valid, rx_ferr;

  ans_rx_parse_uart_rx #(.BAUD_DIV(BAUD_DIV)) u_uart_rx (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_rx      (i_uart_rx),
    .o_data    (rx_data),
    .o_rxvalid (rx_valid),
    .o_ferr    (rx_ferr)
  );

  // Returns {is_hex, nibble}
  function automatic logic [4:0] hex_dec(input logic [7:0] c);
    logic [4:0] r;
    r = '0;
    if (c >= 8'h30 && c <= 8'h39)      r = {1'b1, 4'(c - 8'h30)};
    else if (c >= 8'h41 && c <= 8'h46) r = {1'b1, 4'(c - 8'h37)};
    else if (c >= 8'h61 && c <= 8'h66) r = {1'b1, 4'(c - 8'h57)};
    return r;
  endfunction

  logic [2:0]                state, state_nxt;
  logic [2:0]                field, field_nxt;
  logic [2:0]                nib, nib_nxt;
  logic [3:0][PH_W-1:0]      sh_ph, sh_ph_nxt;
  logic [FREQ_W-1:0]         sh_freq, sh_freq_nxt;
  logic [3:0][PH_W-1:0]      ph_q;
  logic [4:0]                hex;
  logic                      commit, bad;

  always_comb begin
    state_nxt   = state;
    field_nxt   = field;
    nib_nxt     = nib;
    sh_ph_nxt   = sh_ph;
    sh_freq_nxt = sh_freq;
    commit      = 1'b0;
    bad         = 1'b0;
    hex         = hex_dec(rx_data);
    if (rx_valid) begin
      if (state == ST_SYNC) begin
        if (!rx_ferr && rx_data == CHR_LF) state_nxt = ST_DATA;
      end else if (rx_ferr) begin
        bad = 1'b1;
      end else if (rx_data == CHR_LF) begin
        if (state == ST_LF) commit = 1'b1;
        else                bad    = 1'b1;
      end else begin
        case (state)
          ST_DATA: begin
            // Phase fields are 29 bits, so their leading hex digit may only be 0 or 1
            if (!hex[4] || (field != 3'd4 && nib == 3'd0 && hex[3:1] != 3'd0)) begin
              bad = 1'b1;
            end else begin
              if (field == 3'd4) sh_freq_nxt = {sh_freq[FREQ_W-5:0], hex[3:0]};
              else sh_ph_nxt[field[1:0]] = {sh_ph[field[1:0]][PH_W-5:0], hex[3:0]};
              if (field != 3'd4 && nib == 3'd7)      state_nxt = ST_SEP;
              else if (field == 3'd4 && nib == 3'd6) state_nxt = ST_CR;
              else                                   nib_nxt   = nib + 3'd1;
            end
          end
          ST_SEP: begin
            if (rx_data == CHR_COMMA) begin
              field_nxt = field + 3'd1;
              nib_nxt   = '0;
              state_nxt = ST_DATA;
            end else begin
              bad = 1'b1;
            end
          end
          ST_CR: begin
            if (rx_data == CHR_CR) state_nxt = ST_LF;
            else                   bad       = 1'b1;
          end
          default: bad = 1'b1;
        endcase
      end
      if (commit) begin
        state_nxt = ST_DATA;
        field_nxt = '0;
        nib_nxt   = '0;
      end
      // An early LF already marks a line start, so only other errors need a resync
      if (bad) begin
        state_nxt = (!rx_ferr && rx_data == CHR_LF) ? ST_DATA : ST_SYNC;
        field_nxt = '0;
        nib_nxt   = '0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= ST_DATA;
      field     <= '0;
      nib       <= '0;
      sh_ph     <= '0;
      sh_freq   <= '0;
      ph_q      <= '0;
      o_freq    <= '0;
      o_valid   <= 1'b0;
      o_err     <= 1'b0;
      o_err_cnt <= '0;
    end else begin
      state   <= state_nxt;
      field   <= field_nxt;
      nib     <= nib_nxt;
      sh_ph   <= sh_ph_nxt;
      sh_freq <= sh_freq_nxt;
      o_valid <= commit;
      o_err   <= bad;
      if (commit) begin
        ph_q   <= sh_ph;
        o_freq <= sh_freq;
      end
      if (bad && o_err_cnt != '1) o_err_cnt <= o_err_cnt + ERR_W'(1);
    end
  end

  assign o_ph1 = ph_q[0];
  assign o_ph2 = ph_q[1];
  assign o_ph3 = ph_q[2];
  assign o_ph4 = ph_q[3];

endmodule

// File: tb/tb_ans_rx_parse.sv
// Scoreboard bench for ans_rx_parse: line-level reference model, UART byte driver, event monitor.
module tb_ans_rx_parse;

  localparam int BAUD = 6;

  typedef logic [7:0] u8;
  typedef struct packed {
    logic             is_err;
    logic [3:0][28:0] ph;
    logic [27:0]      freq;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx;
  logic [28:0] ph1, ph2, ph3, ph4;
  logic [27:0] freq;
  logic        valid, err;
  logic [7:0]  err_cnt;

  exp_t exp_q[$];
  exp_t last_ok;
  exp_t mon_e;
  exp_t mon_ref;
  int   model_cnt;
  int   checks   = 0;
  int   failures = 0;

  ans_rx_parse #(.BAUD_DIV(BAUD), .ERR_W(8)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_uart_rx (rx),
    .o_ph1     (ph1),
    .o_ph2     (ph2),
    .o_ph3     (ph3),
    .o_ph4     (ph4),
    .o_freq    (freq),
    .o_valid   (valid),
    .o_err     (err),
    .o_err_cnt (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic int hexval(input u8 c);
    if (c >= "0" && c <= "9") return int'(c) - 48;
    if (c >= "A" && c <= "F") return int'(c) - 55;
    if (c >= "a" && c <= "f") return int'(c) - 87;
    return -1;
  endfunction

  function automatic u8 hexchr(input int d, input bit upper);
    if (d < 10) return u8'(48 + d);
    return upper ? u8'(55 + d) : u8'(87 + d);
  endfunction

  // Judges one LF-terminated line as a whole: accepted with its values, or rejected
  function automatic exp_t eval_seg(input u8 seg[$], input bit fe);
    exp_t e;
    int d;
    bit ok;
    int unsigned acc[5];
    e = '0;
    e.is_err = 1'b1;
    if (fe || seg.size() != 45) return e;
    ok = 1'b1;
    for (int k = 0; k < 5; k++) acc[k] = 0;
    for (int i = 0; i < 45; i++) begin
      if (i == 43) ok &= (seg[i] == 8'h0D);
      else if (i == 44) ok &= (seg[i] == 8'h0A);
      else if (i < 36 && i % 9 == 8) ok &= (seg[i] == ",");
      else begin
        d = hexval(seg[i]);
        if (d < 0) ok = 1'b0;
        else begin
          if (i < 36 && i % 9 == 0 && d > 1) ok = 1'b0;
          acc[i/9] = acc[i/9] * 16 + unsigned'(d);
        end
      end
    end
    if (ok) begin
      e.is_err = 1'b0;
      for (int k = 0; k < 4; k++) e.ph[k] = 29'(acc[k]);
      e.freq = 28'(acc[4]);
    end
    return e;
  endfunction

  task automatic send_byte(input u8 b, input bit stop_ok);
    rx = 1'b0;
    repeat (BAUD) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BAUD) @(posedge clk);
    end
    rx = stop_ok;
    repeat (BAUD) @(posedge clk);
    rx = 1'b1;
    if (!stop_ok) repeat (BAUD) @(posedge clk);
  endtask

  // Predict every complete line in the stream, then transmit it
  task automatic send_stream(input u8 q[$], input int fe_idx);
    u8  seg[$];
    bit sfe;
    sfe = 1'b0;
    foreach (q[i]) begin
      seg.push_back(q[i]);
      if (i == fe_idx) sfe = 1'b1;
      if (q[i] == 8'h0A) begin
        exp_q.push_back(eval_seg(seg, sfe));
        seg.delete();
        sfe = 1'b0;
      end
    end
    foreach (q[i]) send_byte(q[i], i != fe_idx);
  endtask

  task automatic send_str(input string s, input int term, input int fe_idx);
    u8 q[$];
    for (int i = 0; i < s.len(); i++) q.push_back(u8'(s[i]));
    if (term == 2) q.push_back(8'h0D);
    if (term >= 1) q.push_back(8'h0A);
    send_stream(q, fe_idx);
  endtask

  task automatic rand_line(output u8 q[$]);
    int d;
    q.delete();
    for (int f = 0; f < 5; f++) begin
      for (int j = 0; j < ((f < 4) ? 8 : 7); j++) begin
        d = (f < 4 && j == 0) ? int'($urandom_range(0, 1)) : int'($urandom_range(0, 15));
        q.push_back(hexchr(d, bit'($urandom_range(0, 1))));
      end
      if (f < 4) q.push_back(8'h2C);
    end
    q.push_back(8'h0D);
    q.push_back(8'h0A);
  endtask

  task automatic drain(input string name);
    for (int t = 0; t < 1000 && exp_q.size() != 0; t++) @(posedge clk);
    chk(name, 64'(exp_q.size()), 0);
  endtask

  task automatic chk_outs(input string tag, input exp_t e);
    chk({tag, "_ph1"}, ph1, e.ph[0]);
    chk({tag, "_ph2"}, ph2, e.ph[1]);
    chk({tag, "_ph3"}, ph3, e.ph[2]);
    chk({tag, "_ph4"}, ph4, e.ph[3]);
    chk({tag, "_freq"}, freq, e.freq);
  endtask

  // Monitor: every valid/err pulse consumes one predicted line outcome
  always @(negedge clk) begin
    if (rst_n === 1'b1 && (valid === 1'b1 || err === 1'b1)) begin
      chk("excl_valid_err", 64'(valid & err), 0);
      if (exp_q.size() == 0) begin
        chk("unexpected_event", 64'(exp_q.size()), 1);
      end else begin
        mon_e = exp_q.pop_front();
        chk("event_kind_err", 64'(err), 64'(mon_e.is_err));
        if (mon_e.is_err) begin
          if (model_cnt < 255) model_cnt++;
          chk("err_cnt", err_cnt, 64'(model_cnt));
          mon_ref = last_ok;
        end else begin
          mon_ref = mon_e;
          last_ok = mon_e;
        end
        chk_outs("mon", mon_ref);
      end
    end
  end

  initial begin
    repeat (98000) @(posedge clk);
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  string l1, l2, l3;
  exp_t  zero_e, s1_e;
  u8     q[$];
  int    mode, fe, p;

  initial begin
    l1 = "0ABCDEF0,1FFFFFFF,00000000,12345678,19BFCC0";
    l2 = "0abcdef0,1FFFFFFF,00000000,12345678,19BFCC0";
    l3 = "0ABCDEF0,2FFFFFFF,00000000,12345678,19BFCC0";
    zero_e = '0;
    s1_e = '0;
    s1_e.ph[0] = 29'h0ABCDEF0;
    s1_e.ph[1] = 29'h1FFFFFFF;
    s1_e.ph[2] = 29'h0;
    s1_e.ph[3] = 29'h12345678;
    s1_e.freq  = 28'h19BFCC0;
    model_cnt = 0;
    last_ok = '0;
    rx = 1'b1;
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk_outs("rst", zero_e);
    chk("rst_valid", 64'(valid), 0);
    chk("rst_err", 64'(err), 0);
    chk("rst_err_cnt", err_cnt, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(posedge clk);

    send_str(l1, 2, -1);
    drain("s1_drain");
    #1;
    chk_outs("s1", s1_e);
    chk("s1_err_cnt", err_cnt, 0);

    send_str(l2, 2, -1);
    drain("s2_drain");
    #1;
    chk_outs("s2", s1_e);

    send_str(l3, 2, -1);
    drain("s3_drain");
    #1;
    chk_outs("s3_held", s1_e);
    chk("s3_err_cnt", err_cnt, 1);
    send_str("1234ABCD,00000001,1ABCDEF9,0FEDCBA9,FFFFFFF", 2, -1);
    drain("s3b_drain");

    send_str("0123", 1, -1);
    send_str(l1, 2, -1);
    drain("s4_drain");
    #1;
    chk_outs("s4", s1_e);

    send_str("XYZ,,12", 2, -1);
    send_str(l2, 2, -1);
    send_str(l1, 2, 5);
    send_str("1000000F,00000000,1FFFFFFF,00000001,ABCDEF1", 2, -1);
    drain("s5_drain");

    for (int n = 0; n < 6; n++) begin
      rand_line(q);
      mode = int'($urandom_range(0, 2));
      fe = -1;
      if (mode == 1) begin
        p = int'($urandom_range(0, 43));
        q[p] = u8'($urandom_range(0, 255));
      end else if (mode == 2) begin
        fe = int'($urandom_range(0, 43));
      end
      send_stream(q, fe);
      drain("rand_drain");
    end

    // Reset part-way through a line: partial line must vanish, not commit or error
    q.delete();
    for (int i = 0; i < l1.len(); i++) q.push_back(u8'(l1[i]));
    q = q[0:19];
    send_stream(q, -1);
    @(negedge clk) rst_n = 1'b0;
    exp_q.delete();
    model_cnt = 0;
    last_ok = '0;
    repeat (3) @(negedge clk);
    chk_outs("s6_rst", zero_e);
    chk("s6_rst_err_cnt", err_cnt, 0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    send_str(l2, 2, -1);
    drain("s6_drain");
    #1;
    chk_outs("s6", s1_e);

    for (int n = 0; n < 300; n++) send_str("", 1, -1);
    drain("sat_drain");
    #1;
    chk("sat_err_cnt", err_cnt, 8'hFF);
    chk_outs("sat_held", s1_e);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
